// File: rtl/spi_sl_regbank.sv
// SPI slave that decodes {rwb, addr, data} frames into a register bank.
// All SPI pins are oversampled on sys_clk; reads are answered within the same frame.
module spi_sl_regbank #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 12,
  parameter int NUM_REGS  = 16,
  parameter int LEDS_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 1,
  parameter int SYNC_STG  = 2
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [LEDS_W-1:0] leds,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        err_cnt
);

  localparam int               CNT_W       = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W);
  localparam int               IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int               AW1         = ADDR_W + 1;
  localparam logic [ADDR_W:0]  NUM_REGS_L  = AW1'(NUM_REGS);
  localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
  localparam bit               SAMPLE_RISE = (CPOL == CPHA);
  localparam bit               LSB         = (LSB_FIRST != 0);
  localparam logic             SCLK_IDLE   = (CPOL != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q;
  logic [SYNC_STG-1:0] sclk_sync_q;
  logic [SYNC_STG-1:0] cs_sync_q;
  logic [SYNC_STG-1:0] mosi_sync_q;
  logic                sclk_prev_q;
  logic                cs_prev_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rwb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rd_q;
  logic                miso_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [7:0]          err_q;
  logic [LEDS_W-1:0]   leds_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic              cs_fall, cs_rise;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d, rd_d, rd_shift_d;
  logic              addr_hit_d, addr_mapped, miso_bit;
  logic              abort, last_data, err_inc;
  logic [7:0]        err_d;

  assign sclk_s = sclk_sync_q[SYNC_STG-1];
  assign cs_s   = cs_sync_q[SYNC_STG-1];
  assign mosi_s = mosi_sync_q[SYNC_STG-1];

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;

  assign addr_d = LSB ? {mosi_s, addr_q[ADDR_W-1:1]} : {addr_q[ADDR_W-2:0], mosi_s};
  assign data_d = LSB ? {mosi_s, data_q[DATA_W-1:1]} : {data_q[DATA_W-2:0], mosi_s};

  // The read word is fetched with the address that is complete on this very sample.
  assign addr_hit_d  = ({1'b0, addr_d} < NUM_REGS_L);
  assign addr_mapped = ({1'b0, addr_q} < NUM_REGS_L);
  assign rd_d        = addr_hit_d ? regs_q[addr_d[IDX_W-1:0]] : '0;
  assign miso_bit    = LSB ? rd_q[0] : rd_q[DATA_W-1];
  assign rd_shift_d  = LSB ? (rd_q >> 1) : (rd_q << 1);

  assign abort     = cs_rise && (state_q inside {S_CMD, S_ADDR, S_DATA});
  assign last_data = (state_q == S_DATA) && !cs_rise && sample_edge && (cnt_q == DATA_LAST);
  assign err_inc   = abort || (last_data && !addr_mapped);
  assign err_d     = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= {SYNC_STG{SCLK_IDLE}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      cs_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rwb_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= '0;
      leds_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      wr_strobe_q <= 1'b0;
      err_q       <= err_d;
      leds_q      <= regs_q[0][LEDS_W-1:0];
      case (state_q)
        S_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q <= S_CMD;
            cnt_q   <= '0;
          end
        end
        S_CMD: begin
          if (cs_rise) begin
            state_q <= S_IDLE;
          end else if (sample_edge) begin
            rwb_q   <= mosi_s;
            cnt_q   <= '0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (cs_rise) begin
            state_q <= S_IDLE;
          end else if (sample_edge) begin
            addr_q <= addr_d;
            if (cnt_q == ADDR_LAST) begin
              cnt_q   <= '0;
              rd_q    <= rwb_q ? rd_d : '0;
              state_q <= S_DATA;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (cs_rise) begin
            miso_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // Each shift edge precedes the sample edge that the master uses for that bit.
            if (shift_edge && rwb_q) begin
              miso_q <= miso_bit;
              rd_q   <= rd_shift_d;
            end
            if (sample_edge) begin
              data_q <= data_d;
              if (cnt_q == DATA_LAST) begin
                state_q <= S_DONE;
                miso_q  <= 1'b0;
                if (!rwb_q && addr_mapped) begin
                  regs_q[addr_q[IDX_W-1:0]] <= data_d;
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= addr_q;
                  wr_data_q   <= data_d;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = ~cs_s;
  assign leds      = leds_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_sl_regbank.sv
// Bench for spi_sl_regbank: bus 0 uses default settings, bus 1 uses CPOL=1, CPHA=1, MSB first.
// A register/error model predicts commits, read words and err_cnt for random frames.
module tb_spi_sl_regbank;

  localparam int HALF = 6;
  localparam int AW   = 6;
  localparam int DW   = 12;
  localparam int NR   = 16;
  localparam int FW   = 1 + AW + DW;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;

  logic [1:0]         sclk_v, cs_n_v, mosi_v;
  logic [1:0]         miso_v, miso_oe_v, wr_strobe_v;
  logic [1:0][7:0]    leds_v, err_v;
  logic [1:0][AW-1:0] wr_addr_v;
  logic [1:0][DW-1:0] wr_data_v;

  logic [AW+DW:0] exp_wr_q[$];  // {bus, addr, data}
  logic [DW:0]    exp_rd_q[$];  // {bus, miso word}
  logic [DW:0]    obs_rd_q[$];

  logic [DW-1:0] mdl_reg [2][NR];
  int            mdl_err [2];
  int            n_tests;
  int            n_fail;

  always #5 sys_clk = ~sys_clk;

  spi_sl_regbank dut0 (
    .sys_clk(sys_clk), .rstn(rstn), .sclk(sclk_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(miso_oe_v[0]), .leds(leds_v[0]), .wr_strobe(wr_strobe_v[0]),
    .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .err_cnt(err_v[0])
  );

  spi_sl_regbank #(.CPOL(1), .CPHA(1), .LSB_FIRST(0)) dut1 (
    .sys_clk(sys_clk), .rstn(rstn), .sclk(sclk_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(miso_oe_v[1]), .leds(leds_v[1]), .wr_strobe(wr_strobe_v[1]),
    .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .err_cnt(err_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic bump_err(input int b);
    mdl_err[b] = (mdl_err[b] < 255) ? mdl_err[b] + 1 : 255;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mdl_err[b] = 0;
      for (int r = 0; r < NR; r++) mdl_reg[b][r] = '0;
    end
  endtask

  // Bus master: bus 0 is mode 0 LSB first, bus 1 is mode 3 MSB first.
  task automatic spi_xfer(input int b, input bit rwb, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int stop_at, input bit leave_low);
    logic [FW-1:0] fr;
    logic [DW-1:0] rd;
    logic          junk;
    bit            cpha, lsb;
    cpha = (b == 1);
    lsb  = (b == 0);
    fr[0] = rwb;
    for (int k = 0; k < AW; k++) fr[1+k] = lsb ? a[k] : a[AW-1-k];
    for (int k = 0; k < DW; k++) fr[1+AW+k] = lsb ? d[k] : d[DW-1-k];
    rd   = '0;
    junk = 1'b0;
    cs_n_v[b] = 1'b0;
    half();
    check("miso_oe", 32'(miso_oe_v[b]), 32'd1);
    for (int i = 0; i < FW && i < stop_at; i++) begin
      if (cpha) sclk_v[b] = ~sclk_v[b];
      mosi_v[b] = fr[i];
      half();
      if (i >= 1 + AW) begin
        if (lsb) rd[i-1-AW] = miso_v[b];
        else     rd[DW-1-(i-1-AW)] = miso_v[b];
      end else begin
        junk = junk | miso_v[b];
      end
      sclk_v[b] = ~sclk_v[b];
      half();
      if (!cpha) sclk_v[b] = ~sclk_v[b];
    end
    if (!leave_low) begin
      cs_n_v[b] = 1'b1;
      mosi_v[b] = 1'b0;
      half();
      half();
    end
    if (stop_at >= FW) begin
      obs_rd_q.push_back({b[0], rd});
      check("miso_quiet_cmd_addr", 32'(junk), 32'd0);
    end
  endtask

  // Issues one frame; expectations are pushed before the frame is driven.
  task automatic do_frame(input int b, input bit rwb, input int addr,
                          input logic [DW-1:0] data, input int stop_at);
    bit mapped;
    mapped = (addr < NR);
    if (stop_at < FW) begin
      bump_err(b);
    end else begin
      if (!mapped) bump_err(b);
      if (rwb) begin
        exp_rd_q.push_back({b[0], mapped ? mdl_reg[b][addr] : {DW{1'b0}}});
      end else begin
        exp_rd_q.push_back({b[0], {DW{1'b0}}});
        if (mapped) begin
          mdl_reg[b][addr] = data;
          exp_wr_q.push_back({b[0], AW'(addr), data});
        end
      end
    end
    spi_xfer(b, rwb, AW'(addr), data, stop_at, 1'b0);
    repeat (4) @(negedge sys_clk);
    check("err_cnt", 32'(err_v[b]), 32'(mdl_err[b]));
    check("leds", 32'(leds_v[b]), 32'(mdl_reg[b][0][7:0]));
  endtask

  task automatic monitor();
    logic [AW+DW:0] ew;
    logic [DW:0]    er, orx;
    bit             led_pend [2];
    logic [7:0]     led_exp  [2];
    logic [7:0]     led_mdl  [2];
    led_pend = '{0, 0};
    led_exp  = '{8'h00, 8'h00};
    led_mdl  = '{8'h00, 8'h00};
    forever begin
      @(negedge sys_clk);
      for (int b = 0; b < 2; b++) begin
        if (!rstn) begin
          led_pend[b] = 0;
          led_mdl[b]  = 8'h00;
        end
        if (led_pend[b]) begin
          check("leds_one_cycle_after_strobe", 32'(leds_v[b]), 32'(led_exp[b]));
          led_mdl[b]  = led_exp[b];
          led_pend[b] = 0;
        end
        if (wr_strobe_v[b]) begin
          if (exp_wr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_strobe: pulse on bus %0d addr 0x%0h, want no pulse", b, wr_addr_v[b]);
          end else begin
            ew = exp_wr_q.pop_front();
            check("wr_commit", 32'({b[0], wr_addr_v[b], wr_data_v[b]}), 32'(ew));
            if (ew[AW+DW] == b[0] && ew[AW+DW-1:DW] == '0) begin
              check("leds_hold_on_strobe", 32'(leds_v[b]), 32'(led_mdl[b]));
              led_exp[b]  = ew[7:0];
              led_pend[b] = 1;
            end
          end
        end
      end
      while (obs_rd_q.size() > 0) begin
        orx = obs_rd_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL miso_word: got 0x%0h, want no frame", orx);
        end else begin
          er = exp_rd_q.pop_front();
          check("miso_word", 32'(orx), 32'(er));
        end
      end
    end
  endtask

  initial begin
    int            b, addr, stop;
    bit            rwb;
    logic [DW-1:0] data;
    n_tests = 0;
    n_fail  = 0;
    sclk_v  = 2'b10;
    cs_n_v  = 2'b11;
    mosi_v  = 2'b00;
    model_reset();
    fork
      monitor();
    join_none
    fork
      begin
        #5000000;
        $display("FAIL watchdog: time limit reached, want end of stimulus");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (5) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_leds", 32'(leds_v[i]), 32'd0);
      check("rst_err_cnt", 32'(err_v[i]), 32'd0);
      check("rst_miso", 32'(miso_v[i]), 32'd0);
      check("rst_miso_oe", 32'(miso_oe_v[i]), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe_v[i]), 32'd0);
      check("rst_wr_addr", 32'(wr_addr_v[i]), 32'd0);
      check("rst_wr_data", 32'(wr_data_v[i]), 32'd0);
    end

    do_frame(0, 1'b0, 12, 12'hABC, FW);
    do_frame(0, 1'b1, 12, 12'h000, FW);
    do_frame(0, 1'b0, 0, 12'h5A5, FW);
    do_frame(0, 1'b0, 20, 12'h111, FW);
    do_frame(0, 1'b1, 20, 12'h000, FW);
    do_frame(0, 1'b0, 3, 12'hFFF, 10);
    do_frame(0, 1'b1, 3, 12'h000, FW);
    do_frame(1, 1'b0, 5, 12'h123, FW);
    do_frame(1, 1'b1, 5, 12'h000, FW);

    for (int n = 0; n < 40; n++) begin
      b    = int'($urandom_range(0, 1));
      rwb  = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 23));
      data = DW'($urandom);
      stop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FW - 1)) : FW;
      do_frame(b, rwb, addr, data, stop);
    end

    for (int n = 0; n < 260; n++) do_frame(1, 1'b0, 0, 12'h000, 0);

    do_frame(0, 1'b0, 0, 12'h0FF, FW);
    spi_xfer(0, 1'b0, 6'd7, 12'h3C3, 8, 1'b1);
    rstn = 1'b0;
    #1;
    check("midframe_rst_leds", 32'(leds_v[0]), 32'd0);
    check("midframe_rst_err0", 32'(err_v[0]), 32'd0);
    check("midframe_rst_err1", 32'(err_v[1]), 32'd0);
    model_reset();
    repeat (2) @(negedge sys_clk);
    cs_n_v[0] = 1'b1;
    mosi_v[0] = 1'b0;
    repeat (4) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    do_frame(0, 1'b0, 1, 12'h777, FW);
    do_frame(0, 1'b1, 1, 12'h000, FW);
    do_frame(0, 1'b1, 0, 12'h000, FW);

    repeat (20) @(negedge sys_clk);
    check("exp_wr_drained", 32'(exp_wr_q.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
